taus113_checker: RTL and testbench

- Receive-side companion to the taus113 generator.
- Consumes the generator's 32-bit output stream over a valid/ready handshake.
- Runs a lock-step taus113 golden model that is reseeded whenever the generator is reseeded, and compares every accepted word against it.
- Reports match/mismatch counts and a lock/fail status; used in on-chip self-test and bench scoreboarding.

---
 rtl/taus113_checker_pkg.sv | 38 +++
 rtl/taus113_checker_if.sv | 9 +
 rtl/taus113_checker_step.sv | 21 ++
 rtl/taus113_checker.sv | 140 ++++++++++++++
 tb/tb_taus113_checker.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/taus113_checker_pkg.sv
// Shared constants, state encoding and seed helper for the taus113 checker.
// Also used by the taus113_step datapath, so the generator can reuse it.
package taus113_checker_pkg;

  localparam logic [31:0] C1 = 32'hFFFF_FFFE;
  localparam logic [31:0] C2 = 32'hFFFF_FFF8;
  localparam logic [31:0] C3 = 32'hFFFF_FFF0;
  localparam logic [31:0] C4 = 32'hFFFF_FF80;

  localparam logic [31:0] DEF_S2   = 32'd8;
  localparam logic [31:0] DEF_S3   = 32'd16;
  localparam logic [31:0] DEF_S4   = 32'd128;
  localparam logic [31:0] SEED_XOR = 32'h0000_0098;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    CHECK    = 2'd1,
    FAIL     = 2'd2
  } chk_state_e;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
    logic [31:0] s4;
  } taus_state_t;

  // The word produced straight after this load is seed ^ SEED_XOR.
  function automatic taus_state_t seed_state(input logic [31:0] seed);
    taus_state_t st;
    st.s1 = seed;
    st.s2 = DEF_S2;
    st.s3 = DEF_S3;
    st.s4 = DEF_S4;
    return st;
  endfunction

endpackage

// File: rtl/taus113_checker_if.sv
// Valid/ready stream carrying taus113 generator words into the checker.
interface taus113_checker_if;
  logic [31:0] rnd;
  logic        rnd_valid;
  logic        rnd_ready;

  modport master (output rnd, output rnd_valid, input  rnd_ready);
  modport slave  (input  rnd, input  rnd_valid, output rnd_ready);
endinterface

// File: rtl/taus113_checker_step.sv
// taus113_step: one combinational taus113 advance plus the output word of the
// current state. Shared between generator and checker so both stay identical.
module taus113_step
  import taus113_checker_pkg::*;
(
  input  taus_state_t i_state,
  output taus_state_t o_next,
  output logic [31:0] o_word
);

  logic [31:0] w_n1, w_n2, w_n3, w_n4;

  assign w_n1 = ((i_state.s1 & C1) << 18) ^ (((i_state.s1 << 6)  ^ i_state.s1) >> 13);
  assign w_n2 = ((i_state.s2 & C2) << 2)  ^ (((i_state.s2 << 2)  ^ i_state.s2) >> 27);
  assign w_n3 = ((i_state.s3 & C3) << 7)  ^ (((i_state.s3 << 13) ^ i_state.s3) >> 21);
  assign w_n4 = ((i_state.s4 & C4) << 13) ^ (((i_state.s4 << 3)  ^ i_state.s4) >> 12);

  assign o_next = {w_n1, w_n2, w_n3, w_n4};
  assign o_word = i_state.s1 ^ i_state.s2 ^ i_state.s3 ^ i_state.s4;

endmodule

// File: rtl/taus113_checker.sv
// Lock-step taus113 stream checker: compares accepted words against a golden model.
// Optional mismatch capture registers are built when TAUS113_CHK_CAPTURE_EN is defined.
module taus113_checker
  import taus113_checker_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int ERR_LIMIT = 1,
  parameter int THROTTLE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  taus113_checker_if.slave s_rnd,
  input  logic [31:0]      i_seed,
  input  logic             i_seed_valid,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_fail,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic [CNT_W-1:0] o_mism_cnt
`ifdef TAUS113_CHK_CAPTURE_EN
  ,
  output logic [31:0]      o_cap_exp,
  output logic [31:0]      o_cap_got,
  output logic [CNT_W-1:0] o_cap_idx
`endif
);

  localparam int          TW      = (THROTTLE > 0) ? $clog2(THROTTLE + 1) : 1;
  localparam logic [TW-1:0] THR_MAX = TW'(THROTTLE);

  chk_state_e       r_state;
  logic             r_locked, r_fail;
  taus_state_t      r_model;
  logic [CNT_W-1:0] r_match, r_mism;
  logic [TW-1:0]    r_thr;

  taus_state_t      w_next;
  logic [31:0]      w_exp;
  logic             w_open, w_ready, w_cmp, w_hit, w_to_fail;
  logic [CNT_W-1:0] w_match_inc, w_mism_inc;

  taus113_step u_step (
    .i_state (r_model),
    .o_next  (w_next),
    .o_word  (w_exp)
  );

  // Throttle closes the port on the last slot of each THROTTLE+1 cycle window.
  assign w_open  = (THROTTLE == 0) ? 1'b1 : (r_thr != THR_MAX);
  assign w_ready = (r_state != UNSEEDED) & ~i_seed_valid & ~i_clear & w_open;
  assign s_rnd.rnd_ready = w_ready;

  assign w_cmp       = s_rnd.rnd_valid & w_ready & (r_state == CHECK);
  assign w_hit       = (s_rnd.rnd == w_exp);
  assign w_match_inc = (r_match == '1) ? r_match : r_match + 1'b1;
  assign w_mism_inc  = (r_mism  == '1) ? r_mism  : r_mism  + 1'b1;
  assign w_to_fail   = w_cmp & ~w_hit & (w_mism_inc >= CNT_W'(ERR_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= UNSEEDED;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
    end else if (i_clear) begin
      r_state  <= UNSEEDED;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
    end else if (i_seed_valid) begin
      r_state  <= CHECK;
      r_locked <= 1'b1;
      r_fail   <= 1'b0;
    end else if (w_to_fail) begin
      r_state  <= FAIL;
      r_locked <= 1'b0;
      r_fail   <= 1'b1;
    end
  end

  // Model and counters freeze outside CHECK; FAIL still drains upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_model <= '0;
      r_match <= '0;
      r_mism  <= '0;
      r_thr   <= '0;
    end else if (i_clear) begin
      r_model <= '0;
      r_match <= '0;
      r_mism  <= '0;
      r_thr   <= '0;
    end else if (i_seed_valid) begin
      r_model <= seed_state(i_seed);
      r_thr   <= '0;
    end else begin
      if (THROTTLE != 0 && r_state != UNSEEDED)
        r_thr <= w_open ? r_thr + 1'b1 : '0;
      if (w_cmp) begin
        r_model <= w_next;
        if (w_hit) r_match <= w_match_inc;
        else       r_mism  <= w_mism_inc;
      end
    end
  end

  assign o_locked    = r_locked;
  assign o_fail      = r_fail;
  assign o_match_cnt = r_match;
  assign o_mism_cnt  = r_mism;

`ifdef TAUS113_CHK_CAPTURE_EN
  logic             r_cap_armed;
  logic [31:0]      r_cap_exp, r_cap_got;
  logic [CNT_W-1:0] r_cap_idx;

  // Only the first mismatch since reset, clear or reseed is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_armed <= 1'b1;
      r_cap_exp   <= '0;
      r_cap_got   <= '0;
      r_cap_idx   <= '0;
    end else if (i_clear || i_seed_valid) begin
      r_cap_armed <= 1'b1;
      r_cap_exp   <= '0;
      r_cap_got   <= '0;
      r_cap_idx   <= '0;
    end else if (w_cmp && !w_hit && r_cap_armed) begin
      r_cap_armed <= 1'b0;
      r_cap_exp   <= w_exp;
      r_cap_got   <= s_rnd.rnd;
      r_cap_idx   <= r_match + r_mism;
    end
  end

  assign o_cap_exp = r_cap_exp;
  assign o_cap_got = r_cap_got;
  assign o_cap_idx = r_cap_idx;
`endif

endmodule

// File: tb/tb_taus113_checker.sv
// Self-checking bench for taus113_checker (ERR_LIMIT=1, THROTTLE=3) with a
// behavioural reference model; capture outputs are checked when TAUS113_CHK_CAPTURE_EN is set.
module tb_taus113_checker;

  localparam int CNT_W     = 32;
  localparam int ERR_LIMIT = 1;
  localparam int THROTTLE  = 3;

  localparam int M_UNS  = 0;
  localparam int M_CHK  = 1;
  localparam int M_FAIL = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  taus113_checker_if u_if ();

  logic [31:0]      seed;
  logic             seed_valid, clear;
  logic             locked, fail;
  logic [CNT_W-1:0] match_cnt, mism_cnt;
`ifdef TAUS113_CHK_CAPTURE_EN
  logic [31:0]      cap_exp, cap_got;
  logic [CNT_W-1:0] cap_idx;
`endif

  taus113_checker #(.CNT_W(CNT_W), .ERR_LIMIT(ERR_LIMIT), .THROTTLE(THROTTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_rnd        (u_if),
    .i_seed       (seed),
    .i_seed_valid (seed_valid),
    .i_clear      (clear),
    .o_locked     (locked),
    .o_fail       (fail),
    .o_match_cnt  (match_cnt),
    .o_mism_cnt   (mism_cnt)
`ifdef TAUS113_CHK_CAPTURE_EN
    ,
    .o_cap_exp    (cap_exp),
    .o_cap_got    (cap_got),
    .o_cap_idx    (cap_idx)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: four generator lanes, mode, cycle phase since seed, counts.
  logic [31:0] m_s [4];
  int          m_mode;
  int          m_phase;
  logic [31:0] m_match, m_mism;
  logic        m_armed;
  logic [31:0] m_cap_exp, m_cap_got, m_cap_idx;
  logic        dut_rdy, m_rdy;

  // Lane recurrence S' = ((S & mask) << q) ^ (((S << s) ^ S) >> r).
  logic [31:0] k_mask [4] = '{32'hFFFFFFFE, 32'hFFFFFFF8, 32'hFFFFFFF0, 32'hFFFFFF80};
  int          k_q    [4] = '{18, 2, 7, 13};
  int          k_s    [4] = '{6, 2, 13, 3};
  int          k_r    [4] = '{13, 27, 21, 12};

  function automatic logic [31:0] m_exp();
    return m_s[0] ^ m_s[1] ^ m_s[2] ^ m_s[3];
  endfunction

  task automatic model_advance();
    for (int i = 0; i < 4; i++)
      m_s[i] = ((m_s[i] & k_mask[i]) << k_q[i]) ^ (((m_s[i] << k_s[i]) ^ m_s[i]) >> k_r[i]);
  endtask

  task automatic model_reset();
    m_s = '{32'd0, 32'd0, 32'd0, 32'd0};
    m_mode = M_UNS; m_phase = 0; m_match = 0; m_mism = 0;
    m_armed = 1'b1; m_cap_exp = 0; m_cap_got = 0; m_cap_idx = 0;
  endtask

  // One clock of stimulus; samples DUT ready mid-cycle and steps the model.
  task automatic drive_cycle(input bit clr, input bit sv, input logic [31:0] sd,
                             input bit vld, input logic [31:0] word);
    logic [31:0] e;
    clear = clr; seed_valid = sv; seed = sd; u_if.rnd_valid = vld; u_if.rnd = word;
    m_rdy = (m_mode != M_UNS) && !sv && !clr && ((m_phase % (THROTTLE + 1)) != THROTTLE);
    @(negedge clk);
    dut_rdy = u_if.rnd_ready;
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else if (sv) begin
      m_s = '{sd, 32'd8, 32'd16, 32'd128};
      m_mode = M_CHK; m_phase = 0;
      m_armed = 1'b1; m_cap_exp = 0; m_cap_got = 0; m_cap_idx = 0;
    end else begin
      if (m_mode != M_UNS) m_phase++;
      if (vld && m_rdy && m_mode == M_CHK) begin
        e = m_exp();
        if (word == e) begin
          if (m_match != 32'hFFFFFFFF) m_match++;
        end else begin
          if (m_armed) begin
            m_armed = 1'b0; m_cap_exp = e; m_cap_got = word; m_cap_idx = m_match + m_mism;
          end
          if (m_mism != 32'hFFFFFFFF) m_mism++;
          if (m_mism >= ERR_LIMIT) m_mode = M_FAIL;
        end
        model_advance();
      end
    end
    clear = 1'b0; seed_valid = 1'b0; u_if.rnd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 0; seed_valid = 0; seed = 0; u_if.rnd_valid = 0; u_if.rnd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (u_if.rnd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", u_if.rnd_ready); end
    n_vec++; if ({locked, fail} !== 2'b00) begin n_err++; $display("FAIL reset_status: got locked=%b fail=%b want 0 0", locked, fail); end
    n_vec++; if (match_cnt !== 0 || mism_cnt !== 0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", match_cnt, mism_cnt); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive_cycle(0, 0, 0, 1, 32'h98);
    n_vec++; if (dut_rdy !== 1'b0) begin n_err++; $display("FAIL unseeded_ready: got %b want 0", dut_rdy); end
  endtask

  task automatic test_match();
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 32'h0, 0, 0);
    drive_cycle(0, 0, 0, 1, 32'h00000098);
    drive_cycle(0, 0, 0, 1, 32'h00100820);
    n_vec++; if (dut_rdy !== 1'b1) begin n_err++; $display("FAIL match_ready: got %b want 1", dut_rdy); end
    n_vec++; if (match_cnt !== 2) begin n_err++; $display("FAIL match_cnt: got %0d want 2", match_cnt); end
    n_vec++; if (mism_cnt !== 0) begin n_err++; $display("FAIL match_mism: got %0d want 0", mism_cnt); end
    n_vec++; if ({locked, fail} !== 2'b10) begin n_err++; $display("FAIL match_status: got locked=%b fail=%b want 1 0", locked, fail); end
  endtask

  task automatic test_mismatch_fail();
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 32'h0, 0, 0);
    drive_cycle(0, 0, 0, 1, 32'h00000098);
    drive_cycle(0, 0, 0, 1, 32'h00100821);
    n_vec++; if (mism_cnt !== 1 || match_cnt !== 1) begin n_err++; $display("FAIL mism_counts: got %0d/%0d want 1/1", match_cnt, mism_cnt); end
    n_vec++; if ({locked, fail} !== 2'b01) begin n_err++; $display("FAIL mism_status: got locked=%b fail=%b want 0 1", locked, fail); end
`ifdef TAUS113_CHK_CAPTURE_EN
    n_vec++; if (cap_exp !== 32'h00100820 || cap_got !== 32'h00100821 || cap_idx !== 1) begin
      n_err++; $display("FAIL capture: got exp=%h got=%h idx=%0d want 00100820 00100821 1", cap_exp, cap_got, cap_idx); end
`endif
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, 0, 0, 1, $urandom);
      n_vec++; if (dut_rdy !== m_rdy) begin n_err++; $display("FAIL fail_drain_ready[%0d]: got %b want %b", i, dut_rdy, m_rdy); end
    end
    n_vec++; if (mism_cnt !== 1 || match_cnt !== 1 || fail !== 1'b1) begin
      n_err++; $display("FAIL fail_frozen: got %0d/%0d fail=%b want 1/1 1", match_cnt, mism_cnt, fail); end
  endtask

  task automatic test_seed_collision();
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 32'h12345678, 1, 32'h123456E0);
    n_vec++; if (dut_rdy !== 1'b0) begin n_err++; $display("FAIL collide_ready: got %b want 0", dut_rdy); end
    n_vec++; if (match_cnt !== 0) begin n_err++; $display("FAIL collide_noaccept: got %0d want 0", match_cnt); end
    drive_cycle(0, 0, 0, 1, 32'h123456E0);
    n_vec++; if (match_cnt !== 1 || mism_cnt !== 0 || locked !== 1'b1) begin
      n_err++; $display("FAIL collide_first_word: got %0d/%0d locked=%b want 1/0 1", match_cnt, mism_cnt, locked); end
  endtask

  task automatic test_clear_in_fail();
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 32'h0, 0, 0);
    drive_cycle(0, 0, 0, 1, 32'h00000001);
    n_vec++; if (fail !== 1'b1) begin n_err++; $display("FAIL clear_setup_fail: got %b want 1", fail); end
    drive_cycle(1, 0, 0, 1, 32'h0);
    n_vec++; if (dut_rdy !== 1'b0) begin n_err++; $display("FAIL clear_ready: got %b want 0", dut_rdy); end
    n_vec++; if ({locked, fail} !== 2'b00 || match_cnt !== 0 || mism_cnt !== 0) begin
      n_err++; $display("FAIL clear_state: got locked=%b fail=%b cnt=%0d/%0d want 0 0 0/0", locked, fail, match_cnt, mism_cnt); end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, 0, 1, 32'h98);
      n_vec++; if (dut_rdy !== 1'b0) begin n_err++; $display("FAIL clear_hold_ready[%0d]: got %b want 0", i, dut_rdy); end
    end
    drive_cycle(0, 1, 32'hCAFE0000, 0, 0);
    drive_cycle(0, 0, 0, 1, 32'hCAFE0098);
    n_vec++; if (match_cnt !== 1 || locked !== 1'b1) begin n_err++; $display("FAIL clear_reseed: got %0d locked=%b want 1 1", match_cnt, locked); end
  endtask

  task automatic test_long_stream();
    int acc = 0, cyc = 0, lows = 0, bad = 0;
    bit vld;
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, $urandom, 0, 0);
    while (acc < 10000 && cyc < 40000) begin
      vld = ($urandom_range(0, 2) != 0);
      drive_cycle(0, 0, 0, vld, m_exp());
      cyc++;
      if (!dut_rdy) lows++;
      if (vld && m_rdy) acc++;
      n_vec++; if (dut_rdy !== m_rdy) begin n_err++; bad++;
        if (bad < 5) $display("FAIL stream_ready[%0d]: got %b want %b", cyc, dut_rdy, m_rdy); end
    end
    n_vec++; if (acc != 10000) begin n_err++; $display("FAIL stream_budget: got %0d accepted want 10000", acc); end
    n_vec++; if (lows != cyc / (THROTTLE + 1)) begin n_err++; $display("FAIL stream_throttle: got %0d low cycles want %0d", lows, cyc / (THROTTLE + 1)); end
    n_vec++; if (mism_cnt !== 0 || match_cnt !== 10000) begin n_err++; $display("FAIL stream_counts: got %0d/%0d want 10000/0", match_cnt, mism_cnt); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL stream_locked: got %b want 1", locked); end
  endtask

  task automatic test_random_mix();
    int r, bad = 0;
    logic [31:0] w;
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      w = m_exp();
      if ($urandom_range(0, 49) == 0) w = w ^ (32'h1 << $urandom_range(0, 31));
      if (r < 2)       drive_cycle(1, 0, 0, $urandom_range(0, 1), w);
      else if (r < 7)  drive_cycle(0, 1, $urandom, $urandom_range(0, 1), w);
      else             drive_cycle(0, 0, 0, ($urandom_range(0, 3) != 0), w);
      n_vec++;
      if (dut_rdy !== m_rdy || match_cnt !== m_match || mism_cnt !== m_mism ||
          locked !== (m_mode == M_CHK) || fail !== (m_mode == M_FAIL)) begin
        n_err++; bad++;
        if (bad < 5) $display("FAIL mix[%0d]: got rdy=%b cnt=%0d/%0d l=%b f=%b want rdy=%b cnt=%0d/%0d l=%b f=%b",
          c, dut_rdy, match_cnt, mism_cnt, locked, fail, m_rdy, m_match, m_mism, m_mode == M_CHK, m_mode == M_FAIL);
      end
`ifdef TAUS113_CHK_CAPTURE_EN
      n_vec++;
      if (cap_exp !== m_cap_exp || cap_got !== m_cap_got || cap_idx !== m_cap_idx) begin
        n_err++; bad++;
        if (bad < 5) $display("FAIL mix_cap[%0d]: got %h %h %0d want %h %h %0d", c, cap_exp, cap_got, cap_idx, m_cap_exp, m_cap_got, m_cap_idx);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 32'h5A5A0000, 0, 0);
    repeat (3) drive_cycle(0, 0, 0, 1, m_exp());
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++; if (u_if.rnd_ready !== 1'b0 || locked !== 1'b0 || fail !== 1'b0) begin
      n_err++; $display("FAIL async_status: got rdy=%b locked=%b fail=%b want 0 0 0", u_if.rnd_ready, locked, fail); end
    n_vec++; if (match_cnt !== 0 || mism_cnt !== 0) begin n_err++; $display("FAIL async_counts: got %0d/%0d want 0/0", match_cnt, mism_cnt); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    drive_cycle(0, 0, 0, 1, 32'h98);
    n_vec++; if (dut_rdy !== 1'b0 || locked !== 1'b0) begin n_err++; $display("FAIL async_needs_seed: got rdy=%b locked=%b want 0 0", dut_rdy, locked); end
    drive_cycle(0, 1, 32'h0, 0, 0);
    drive_cycle(0, 0, 0, 1, 32'h98);
    n_vec++; if (match_cnt !== 1 || locked !== 1'b1) begin n_err++; $display("FAIL async_resume: got %0d locked=%b want 1 1", match_cnt, locked); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch_fail();
    test_seed_collision();
    test_clear_in_fail();
    test_long_stream();
    test_random_mix();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
